divisor_secuencial_param: RTL and testbench



---
 rtl/divisor_secuencial_param_if.sv | 41 ++++
 rtl/divisor_secuencial_param.sv | 200 ++++++++++++++++++++
 tb/tb_divisor_secuencial_param.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/divisor_secuencial_param_if.sv
// ============================================================================
// Module      : divisor_secuencial_param_if
// Description : Start/Done/Busy handshake and operand/result bundle for the
//               sequential divider. DivZero exists only with DIVISOR_DIVZERO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface divisor_secuencial_param_if #(
    parameter int tamanyo = 32
);
    logic               Start;
    logic               Signed;
    logic [tamanyo-1:0] Num;
    logic [tamanyo-1:0] Den;
    logic [tamanyo-1:0] Coc;
    logic [tamanyo-1:0] Res;
    logic               Done;
    logic               Busy;
`ifdef DIVISOR_DIVZERO_EN
    logic               DivZero;
`endif

    modport master (
        output Start, Signed, Num, Den,
        input  Coc, Res, Done, Busy
`ifdef DIVISOR_DIVZERO_EN
        , input DivZero
`endif
    );

    modport slave (
        input  Start, Signed, Num, Den,
        output Coc, Res, Done, Busy
`ifdef DIVISOR_DIVZERO_EN
        , output DivZero
`endif
    );
endinterface

`default_nettype wire

// File: rtl/divisor_secuencial_param.sv
// ============================================================================
// Module      : divisor_secuencial_param
// Description : Radix-2 restoring sequential divider, signed/unsigned per
//               operation, fixed latency tamanyo+2. Optional early exit on
//               divide-by-zero with DivZero flag when DIVISOR_DIVZERO_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divisor_secuencial_param #(
    parameter int tamanyo = 32
) (
    input  wire logic                   CLK,
    input  wire logic                   RSTa,
    divisor_secuencial_param_if.slave   bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ITER  = 2'd1;
    localparam logic [1:0] c_FIX   = 2'd2;
    localparam int         c_CNT_W = $clog2(tamanyo + 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;

    logic                w_load;
    logic                w_iter;
    logic                w_fix;
    logic                w_busy;

    logic [tamanyo-1:0]  r_quo;
    logic [tamanyo:0]    r_rem;
    logic [tamanyo-1:0]  r_den_mag;
    logic [tamanyo-1:0]  r_num_orig;
    logic                r_sign_num;
    logic                r_sign_den;
    logic                r_den_zero;
    logic [c_CNT_W-1:0]  r_cnt;

    logic [tamanyo-1:0]  r_coc;
    logic [tamanyo-1:0]  r_res;
    logic                r_done;

    logic                w_num_neg;
    logic                w_den_neg;
    logic [tamanyo-1:0]  w_num_mag;
    logic [tamanyo-1:0]  w_den_mag;
    logic [tamanyo+1:0]  w_diff;
    logic                w_ge;
    logic [tamanyo-1:0]  w_coc;
    logic [tamanyo-1:0]  w_res;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.Start) begin
`ifdef DIVISOR_DIVZERO_EN
                    w_state_next = (bus.Den == '0) ? c_FIX : c_ITER;
`else
                    w_state_next = c_ITER;
`endif
                end
            end
            c_ITER: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_state_next = c_FIX;
                end
            end
            c_FIX:   w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded controls
    // ------------------------------------------------------------------
    always_comb begin
        w_load = 1'b0;
        w_iter = 1'b0;
        w_fix  = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            c_IDLE: w_load = bus.Start;
            c_ITER: begin
                w_iter = 1'b1;
                w_busy = 1'b1;
            end
            c_FIX: begin
                w_fix  = 1'b1;
                w_busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Sign bits are forced to 0 in unsigned mode so magnitudes equal inputs.
    assign w_num_neg = bus.Signed & bus.Num[tamanyo-1];
    assign w_den_neg = bus.Signed & bus.Den[tamanyo-1];
    assign w_num_mag = w_num_neg ? (-bus.Num) : bus.Num;
    assign w_den_mag = w_den_neg ? (-bus.Den) : bus.Den;

    // Trial subtraction on the shifted partial remainder; the top remainder
    // bit is always 0 between iterations, so the extra MSB flags a borrow.
    assign w_diff = {r_rem, r_quo[tamanyo-1]} - {2'b00, r_den_mag};
    assign w_ge   = ~w_diff[tamanyo+1];

    // Truncating-division sign fix, overridden by the divide-by-zero result.
    always_comb begin
        w_coc = r_quo;
        w_res = r_rem[tamanyo-1:0];
        if (r_den_zero) begin
            w_coc = '1;
            w_res = r_num_orig;
        end else begin
            if (r_sign_num ^ r_sign_den) begin
                w_coc = -r_quo;
            end
            if (r_sign_num) begin
                w_res = -r_rem[tamanyo-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            r_quo      <= '0;
            r_rem      <= '0;
            r_den_mag  <= '0;
            r_num_orig <= '0;
            r_sign_num <= 1'b0;
            r_sign_den <= 1'b0;
            r_den_zero <= 1'b0;
            r_cnt      <= '0;
            r_coc      <= '0;
            r_res      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_load) begin
                r_quo      <= w_num_mag;
                r_rem      <= '0;
                r_den_mag  <= w_den_mag;
                r_num_orig <= bus.Num;
                r_sign_num <= w_num_neg;
                r_sign_den <= w_den_neg;
                r_den_zero <= (bus.Den == '0);
                r_cnt      <= c_CNT_W'(tamanyo);
            end else if (w_iter) begin
                r_quo <= {r_quo[tamanyo-2:0], w_ge};
                r_rem <= w_ge ? w_diff[tamanyo:0]
                              : {r_rem[tamanyo-1:0], r_quo[tamanyo-1]};
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            if (w_fix) begin
                r_coc <= w_coc;
                r_res <= w_res;
            end
        end
    end

`ifdef DIVISOR_DIVZERO_EN
    logic r_divzero;

    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            r_divzero <= 1'b0;
        end else begin
            r_divzero <= w_fix & r_den_zero;
        end
    end

    assign bus.DivZero = r_divzero;
`endif

    assign bus.Coc  = r_coc;
    assign bus.Res  = r_res;
    assign bus.Done = r_done;
    assign bus.Busy = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_divisor_secuencial_param.sv
// Randomised scoreboard bench for divisor_secuencial_param (tamanyo = 8):
// reference results come from plain integer division in the bench.
`default_nettype none

module tb_divisor_secuencial_param;

    localparam int T = 8;

    logic CLK  = 1'b0;
    logic RSTa = 1'b0;
    int   cyc  = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    divisor_secuencial_param_if #(.tamanyo(T)) bus ();

    divisor_secuencial_param #(.tamanyo(T)) dut (
        .CLK  (CLK),
        .RSTa (RSTa),
        .bus  (bus)
    );

    typedef struct {
        logic [T-1:0] coc;
        logic [T-1:0] res;
        bit           dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input logic [T-1:0] d);
`ifdef DIVISOR_DIVZERO_EN
        if (d == '0) return 2;
`endif
        return T + 2;
    endfunction

    // Truncating division: Num = Coc*Den + Res; x/0 gives all ones and Num.
    function automatic exp_t model(input bit s, input logic [T-1:0] n,
                                   input logic [T-1:0] d, input int c);
        exp_t   e;
        longint a, b, q, r;
        if (d == '0) begin
            e.coc = '1;
            e.res = n;
        end else begin
            if (s) begin
                a = longint'($signed(n));
                b = longint'($signed(d));
            end else begin
                a = longint'(n);
                b = longint'(d);
            end
            q = a / b;
            r = a % b;
            e.coc = q[T-1:0];
            e.res = r[T-1:0];
        end
        e.dz  = (d == '0);
        e.cyc = c + lat_of(d);
        return e;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start_op(input bit s, input logic [T-1:0] n, input logic [T-1:0] d);
        sb.push_back(model(s, n, d, cyc));
        bus.Start  = 1'b1;
        bus.Signed = s;
        bus.Num    = n;
        bus.Den    = d;
        @(posedge CLK);
        #1;
        bus.Start  = 1'b0;
        bus.Num    = T'($urandom);
        bus.Den    = T'($urandom);
        chk("busy_after_start", {63'd0, bus.Busy}, 64'd1);
    endtask

    // Leaves the caller in the Done cycle so the next Start is back-to-back.
    task automatic run_op(input bit s, input logic [T-1:0] n, input logic [T-1:0] d);
        start_op(s, n, d);
        wait_cyc(lat_of(d) - 1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_coc"},  {56'd0, bus.Coc}, 64'd0);
        chk({tag, "_res"},  {56'd0, bus.Res}, 64'd0);
        chk({tag, "_done"}, {63'd0, bus.Done}, 64'd0);
        chk({tag, "_busy"}, {63'd0, bus.Busy}, 64'd0);
`ifdef DIVISOR_DIVZERO_EN
        chk({tag, "_divzero"}, {63'd0, bus.DivZero}, 64'd0);
`endif
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RSTa && bus.Done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got Done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("coc",        {56'd0, bus.Coc}, {56'd0, e.coc});
                chk("res",        {56'd0, bus.Res}, {56'd0, e.res});
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_in_done", {63'd0, bus.Busy}, 64'd0);
`ifdef DIVISOR_DIVZERO_EN
                chk("divzero", {63'd0, bus.DivZero}, {63'd0, e.dz});
`endif
            end
        end
    end

    initial begin
        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.Num    = '0;
        bus.Den    = '0;
        RSTa       = 1'b0;
        wait_cyc(3);
        chk_zero_outputs("reset");
        RSTa = 1'b1;
        wait_cyc(1);

        run_op(1'b0, 8'd200, 8'd7);
        run_op(1'b1, 8'hF9, 8'h02);
        run_op(1'b1, 8'h07, 8'hFE);
        run_op(1'b1, 8'h80, 8'hFF);
        run_op(1'b0, 8'h80, 8'hFF);
        run_op(1'b0, 8'h05, 8'h00);
        run_op(1'b1, 8'hFB, 8'h00);
        run_op(1'b0, 8'd200, 8'd7);
        run_op(1'b0, 8'd100, 8'd9);

        // Start pulse during Busy must be ignored.
        start_op(1'b0, 8'd50, 8'd3);
        wait_cyc(2);
        bus.Start = 1'b1;
        bus.Num   = 8'd9;
        bus.Den   = 8'd2;
        @(posedge CLK);
        #1;
        bus.Start = 1'b0;
        wait_cyc(T - 2);

        // Operation aborted by reset four cycles after Start.
        bus.Start  = 1'b1;
        bus.Signed = 1'b0;
        bus.Num    = 8'd77;
        bus.Den    = 8'd5;
        @(posedge CLK);
        #1;
        bus.Start = 1'b0;
        wait_cyc(3);
        RSTa = 1'b0;
        @(posedge CLK);
        #1;
        chk_zero_outputs("midop_reset");
        RSTa = 1'b1;
        wait_cyc(T + 4);
        run_op(1'b0, 8'd100, 8'd9);

        for (int i = 0; i < 40; i++) begin
            logic [T-1:0] n, d;
            bit           s;
            s = 1'($urandom_range(0, 1));
            n = T'($urandom);
            d = ($urandom_range(0, 7) == 0) ? '0 : T'($urandom);
            run_op(s, n, d);
        end

        wait_cyc(3);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
